dtw_axis_ingest: RTL and testbench

- Parametrised AXIS sample ingest front-end for the DTW core. It replaces the fixed 32-bit, one-sample-per-beat input path.
- Unpacks SAMPLES_PER_WORD samples of SAMPLE_WIDTH bits from each AXIS beat.
- Frames samples using tuser (frame start) and tlast (frame end), then buffers them in a show-ahead FIFO.
- Presents a valid/ready sample stream with first/last flags and per-frame length reporting. Sits between the PS DMA stream and the DTW compute engine.

---
 rtl/dtw_axis_ingest_if.sv | 28 ++
 rtl/dtw_axis_ingest.sv | 209 ++++++++++++++++++++
 tb/tb_dtw_axis_ingest.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_axis_ingest_if.sv
// ---------------------------------------------------------------------------
// dtw_axis_ingest_if
// AXI4-Stream beat bundle carrying packed DTW samples from the PS DMA into
// the ingest front-end.
//
// Signals:
//   tuser   frame start marker on the beat
//   tvalid  beat valid
//   tready  beat accepted when tvalid & tready
//   tlast   frame end marker on the beat
//   tdata   DATA_WIDTH bits of packed samples, lane 0 in the LSBs
//
// Modports:
//   master  stream source (DMA side / testbench)
//   slave   stream sink (dtw_axis_ingest)
// ---------------------------------------------------------------------------
interface dtw_axis_ingest_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tuser;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tuser, output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tuser, input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/dtw_axis_ingest.sv
// ---------------------------------------------------------------------------
// dtw_axis_ingest
// Sample ingest front-end for the DTW core. Each accepted AXIS beat carries
// SAMPLES_PER_WORD samples of SAMPLE_WIDTH bits. Beats are framed with tuser
// (start) and tlast (end), unpacked one lane per cycle into a show-ahead
// FIFO, and presented to the compute engine as a valid/ready sample stream
// with first/last flags and per-frame length reporting.
//
// Ports:
//   S_AXIS_clk, S_AXIS_rst  clock, asynchronous active-high reset
//   S_AXIS                  AXIS slave (tuser, tvalid, tready, tlast, tdata)
//   i_flush                 synchronous flush of unpacker, FIFO and frame state
//   o_sample/_first/_last   FIFO head sample and its frame flags
//   o_sample_valid          FIFO not empty
//   i_sample_ready          consumer pops the head when valid & ready
//   o_fifo_level            entries held in the FIFO
//   o_frame_done            one-cycle pulse when a frame closes
//   o_frame_len             sample count of the last closed frame (held)
//   o_truncated             with o_frame_done: frame closed by a new tuser
//
// Optional build macro DTW_INGEST_STATS_EN adds:
//   o_frames                wrapping count of closed frames (incl. truncated)
//   o_discard               wrapping count of beats discarded outside a frame
// ---------------------------------------------------------------------------
module dtw_axis_ingest #(
    parameter int AXIS_DATA_WIDTH  = 32,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SAMPLES_PER_WORD = 2,
    parameter int FIFO_DEPTH       = 16,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                          S_AXIS_clk,
    input  logic                          S_AXIS_rst,
    dtw_axis_ingest_if.slave              S_AXIS,
    input  logic                          i_flush,
    output logic [SAMPLE_WIDTH-1:0]       o_sample,
    output logic                          o_sample_first,
    output logic                          o_sample_last,
    output logic                          o_sample_valid,
    input  logic                          i_sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_frame_done,
    output logic [LEN_WIDTH-1:0]          o_frame_len,
    output logic                          o_truncated
`ifdef DTW_INGEST_STATS_EN
    ,
    output logic [31:0]                   o_frames,
    output logic [31:0]                   o_discard
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LANE_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SAMPLES_PER_WORD - 1);
    localparam logic [PTR_W:0]    FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Unpacker: one held beat plus the lane currently being written
    logic [SAMPLES_PER_WORD-1:0][SAMPLE_WIDTH-1:0] hold_data;
    logic                 hold_first, hold_last, unpack_full;
    logic [LANE_W-1:0]    lane;

    // FIFO storage is {first, last, sample}
    logic [SAMPLE_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr, rd_ptr, level;
    logic [SAMPLE_WIDTH+1:0] head;
    logic                    fifo_full, fifo_empty;

    logic wr_en, wr_last_lane, wr_first_flag, wr_last_flag, rd_en;
    logic accept, load, frame_open;
    logic close_trunc, close_last;
    logic [LEN_WIDTH-1:0] frame_cnt, cnt_inc;

    assign level       = wr_ptr - rd_ptr;
    assign fifo_full   = (level == FULL_LEVEL);
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign head        = mem[rd_ptr[PTR_W-1:0]];

    assign wr_en         = unpack_full && !fifo_full && !i_flush;
    assign wr_last_lane  = wr_en && (lane == LAST_LANE);
    assign wr_first_flag = hold_first && (lane == '0);
    assign wr_last_flag  = hold_last && (lane == LAST_LANE);
    assign rd_en         = !fifo_empty && i_sample_ready && !i_flush;

    // Ready is gated by reset so the source sees 0 throughout reset; the
    // last-lane term lets a new beat land as the held one drains.
    assign S_AXIS.tready = !S_AXIS_rst && !i_flush && (!unpack_full || wr_last_lane);
    assign accept        = S_AXIS.tvalid && S_AXIS.tready;

    assign close_trunc = wr_en && wr_first_flag && (frame_cnt != '0);
    assign close_last  = wr_en && wr_last_flag;
    assign cnt_inc     = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;

    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // A frame whose tlast beat is already held is closed from the acceptor's
    // point of view, so further non-tuser beats are discarded, not appended.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        frame_open = (state_q == FRAME) && !(unpack_full && hold_last);
        if (accept && (S_AXIS.tuser || frame_open)) load = 1'b1;
        case (state_q)
            IDLE:    if (load) state_d = FRAME;
            FRAME:   if (wr_last_lane && hold_last && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) begin
            hold_data   <= '0;
            hold_first  <= 1'b0;
            hold_last   <= 1'b0;
            unpack_full <= 1'b0;
            lane        <= '0;
        end else if (i_flush) begin
            unpack_full <= 1'b0;
            lane        <= '0;
        end else if (load) begin
            hold_data   <= S_AXIS.tdata;
            hold_first  <= S_AXIS.tuser;
            hold_last   <= S_AXIS.tlast;
            unpack_full <= 1'b1;
            lane        <= '0;
        end else if (wr_en) begin
            if (wr_last_lane) unpack_full <= 1'b0;
            else              lane <= lane + 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_clk) begin
        if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= {wr_first_flag, wr_last_flag, hold_data[lane]};
    end

    // A new frame start closes any open frame as truncated; its own lane 0
    // then counts as sample 1 of the new frame.
    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) begin
            frame_cnt    <= '0;
            o_frame_done <= 1'b0;
            o_frame_len  <= '0;
            o_truncated  <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_truncated  <= 1'b0;
            if (i_flush) begin
                frame_cnt <= '0;
            end else if (close_trunc) begin
                o_frame_done <= 1'b1;
                o_truncated  <= 1'b1;
                o_frame_len  <= frame_cnt;
                frame_cnt    <= wr_last_flag ? '0 : LEN_WIDTH'(1);
            end else if (close_last) begin
                o_frame_done <= 1'b1;
                o_frame_len  <= cnt_inc;
                frame_cnt    <= '0;
            end else if (wr_en) begin
                frame_cnt <= cnt_inc;
            end
        end
    end

`ifdef DTW_INGEST_STATS_EN
    always_ff @(posedge S_AXIS_clk or posedge S_AXIS_rst) begin
        if (S_AXIS_rst) begin
            o_frames  <= '0;
            o_discard <= '0;
        end else if (i_flush) begin
            o_frames  <= '0;
            o_discard <= '0;
        end else begin
            if (close_trunc || close_last) o_frames <= o_frames + 1'b1;
            if (accept && !load)           o_discard <= o_discard + 1'b1;
        end
    end
`endif

    // Head outputs are masked while empty so the unreset RAM never shows
    assign o_sample       = fifo_empty ? '0 : head[SAMPLE_WIDTH-1:0];
    assign o_sample_first = !fifo_empty && head[SAMPLE_WIDTH+1];
    assign o_sample_last  = !fifo_empty && head[SAMPLE_WIDTH];
    assign o_sample_valid = !fifo_empty;
    assign o_fifo_level   = level;

endmodule

// File: tb/tb_dtw_axis_ingest.sv
// ---------------------------------------------------------------------------
// tb_dtw_axis_ingest
// Directed and randomized bench for dtw_axis_ingest (default parameters:
// 2 x 16-bit samples per 32-bit beat, 16-entry FIFO). A frame-level model
// turns each accepted beat into expected samples and frame reports; the
// monitor compares every pop and every o_frame_done pulse against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dtw_axis_ingest;

    localparam int SW    = 16;
    localparam int SPW   = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic ready = 1'b0;

    always #5 clk = ~clk;

    dtw_axis_ingest_if #(.DATA_WIDTH(DW)) s_axis ();

    logic [SW-1:0]          o_sample;
    logic                   o_first, o_last, o_valid, o_done, o_trunc;
    logic [$clog2(DEPTH):0] o_level;
    logic [LW-1:0]          o_len;
`ifdef DTW_INGEST_STATS_EN
    logic [31:0]            o_frames, o_discard;
`endif

    dtw_axis_ingest #(
        .AXIS_DATA_WIDTH (DW),
        .SAMPLE_WIDTH    (SW),
        .SAMPLES_PER_WORD(SPW),
        .FIFO_DEPTH      (DEPTH),
        .LEN_WIDTH       (LW)
    ) dut (
        .S_AXIS_clk    (clk),
        .S_AXIS_rst    (rst),
        .S_AXIS        (s_axis),
        .i_flush       (flush),
        .o_sample      (o_sample),
        .o_sample_first(o_first),
        .o_sample_last (o_last),
        .o_sample_valid(o_valid),
        .i_sample_ready(ready),
        .o_fifo_level  (o_level),
        .o_frame_done  (o_done),
        .o_frame_len   (o_len),
        .o_truncated   (o_trunc)
`ifdef DTW_INGEST_STATS_EN
        ,
        .o_frames      (o_frames),
        .o_discard     (o_discard)
`endif
    );

    typedef struct { logic [DW-1:0] data; logic user; logic last; } beat_t;
    typedef struct { logic [SW-1:0] data; logic first; logic last; } samp_t;
    typedef struct { logic trunc; int len; } rep_t;

    beat_t tx_q[$];
    samp_t exp_q[$];
    rep_t  rep_q[$];

    int checks = 0;
    int errors = 0;
    bit m_in_frame = 1'b0;
    int m_count = 0;
    int m_discards = 0;
    int m_frames = 0;
    int accepted_beats = 0;
    int popped_samples = 0;
    bit accept_pending = 1'b0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] data, input logic user, input logic last);
        beat_t b;
        b.data = data;
        b.user = user;
        b.last = last;
        tx_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        exp_q.delete();
        rep_q.delete();
        m_in_frame = 1'b0;
        m_count    = 0;
        m_discards = 0;
        m_frames   = 0;
    endtask

    // Frame semantics: a tuser beat opens a frame (closing any open one as
    // truncated), beats inside a frame contribute all lanes, tlast closes.
    task automatic model_accept(input beat_t b);
        samp_t s;
        rep_t  r;
        if (b.user) begin
            if (m_in_frame && m_count > 0) begin
                r.trunc = 1'b1;
                r.len   = m_count;
                rep_q.push_back(r);
            end
            m_in_frame = 1'b1;
            m_count    = 0;
        end
        if (m_in_frame) begin
            for (int k = 0; k < SPW; k++) begin
                s.data  = b.data[k*SW +: SW];
                s.first = b.user && (k == 0);
                s.last  = b.last && (k == SPW - 1);
                exp_q.push_back(s);
            end
            m_count += SPW;
            if (b.last) begin
                r.trunc = 1'b0;
                r.len   = m_count;
                rep_q.push_back(r);
                m_in_frame = 1'b0;
                m_count    = 0;
            end
        end else begin
            m_discards++;
        end
    endtask

    // Source driver: presents the head of tx_q, advances on handshake
    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tuser  = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
    end

    always @(posedge clk) begin
        #1;
        if (accept_pending && tx_q.size() > 0) tx_q.delete(0);
        if (tx_q.size() > 0) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = tx_q[0].data;
            s_axis.tuser  = tx_q[0].user;
            s_axis.tlast  = tx_q[0].last;
        end else begin
            s_axis.tvalid = 1'b0;
            s_axis.tdata  = '0;
            s_axis.tuser  = 1'b0;
            s_axis.tlast  = 1'b0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            model_clear();
            accept_pending = 1'b0;
        end else begin
            if (o_done) begin
                if (rep_q.size() == 0) begin
                    check_output("frame_report_available", 32'(rep_q.size()), 1);
                end else begin
                    rep_t r;
                    r = rep_q.pop_front();
                    check_output("frame_truncated", {31'b0, o_trunc}, {31'b0, r.trunc});
                    check_output("frame_len", 32'(o_len), r.len);
                    m_frames++;
                end
            end
            accept_pending = s_axis.tvalid && s_axis.tready;
            if (flush) begin
                model_clear();
            end else begin
                if (o_valid && ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("sample_available", 32'(exp_q.size()), 1);
                    end else begin
                        samp_t s;
                        s = exp_q.pop_front();
                        check_output("sample_data", 32'(o_sample), 32'(s.data));
                        check_output("sample_first", {31'b0, o_first}, {31'b0, s.first});
                        check_output("sample_last", {31'b0, o_last}, {31'b0, s.last});
                    end
                    popped_samples++;
                end
                if (accept_pending && tx_q.size() > 0) begin
                    accepted_beats++;
                    model_accept(tx_q[0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_acc;
        int base_pop;
        bit found;

        // Reset state
        tick(3);
        @(negedge clk);
        check_output("rst_tready", {31'b0, s_axis.tready}, 0);
        check_output("rst_valid", {31'b0, o_valid}, 0);
        check_output("rst_level", 32'(o_level), 0);
        check_output("rst_done", {31'b0, o_done}, 0);
        check_output("rst_len", 32'(o_len), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_output("tready_after_reset", {31'b0, s_axis.tready}, 1);

        // Single-beat frame 0x0002_0001 with tuser+tlast, consumer always ready
        ready = 1'b1;
        tick(1);
        apply_stimulus(32'h0002_0001, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_output("a_handshake", {31'b0, s_axis.tvalid && s_axis.tready}, 1);
        @(negedge clk);
        check_output("a_valid_before_lane0", {31'b0, o_valid}, 0);
        @(negedge clk);
        check_output("a_lane0_valid", {31'b0, o_valid}, 1);
        check_output("a_lane0_data", 32'(o_sample), 32'h0001);
        check_output("a_lane0_first", {31'b0, o_first}, 1);
        check_output("a_lane0_last", {31'b0, o_last}, 0);
        @(negedge clk);
        check_output("a_lane1_data", 32'(o_sample), 32'h0002);
        check_output("a_lane1_first", {31'b0, o_first}, 0);
        check_output("a_lane1_last", {31'b0, o_last}, 1);
        check_output("a_done", {31'b0, o_done}, 1);
        check_output("a_len", 32'(o_len), 2);
        check_output("a_trunc", {31'b0, o_trunc}, 0);
        tick(3);

        // Two beats outside a frame are accepted and dropped
        base_acc = accepted_beats;
        apply_stimulus(32'h1111_2222, 1'b0, 1'b0);
        apply_stimulus(32'h3333_4444, 1'b0, 1'b0);
        tick(8);
        check_output("b_accepted", 32'(accepted_beats - base_acc), 2);
        check_output("b_level", 32'(o_level), 0);
        check_output("b_valid", {31'b0, o_valid}, 0);
`ifdef DTW_INGEST_STATS_EN
        check_output("b_discard", o_discard, 2);
        check_output("b_frames", o_frames, 1);
`endif

        // Back-pressure: 10 beats with the consumer stalled
        ready    = 1'b0;
        base_acc = accepted_beats;
        base_pop = popped_samples;
        for (int i = 0; i < 10; i++)
            apply_stimulus({16'(16'h0101 + 2*i), 16'(16'h0100 + 2*i)}, i == 0, i == 9);
        tick(40);
        check_output("c_level_full", 32'(o_level), 16);
        check_output("c_tready_low", {31'b0, s_axis.tready}, 0);
        check_output("c_beats_taken", 32'(accepted_beats - base_acc), 9);
        ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (tx_q.size() == 0 && exp_q.size() == 0 && !o_valid) found = 1'b1;
            else tick(1);
        end
        check_output("c_drained", {31'b0, found}, 1);
        check_output("c_samples_out", 32'(popped_samples - base_pop), 20);
        check_output("c_tready_back", {31'b0, s_axis.tready}, 1);

        // Mid-frame tuser truncates the open frame
        tick(2);
        apply_stimulus(32'h0A02_0A01, 1'b1, 1'b0);
        apply_stimulus(32'h0A04_0A03, 1'b0, 1'b0);
        apply_stimulus(32'h0A06_0A05, 1'b0, 1'b0);
        apply_stimulus(32'h0B02_0B01, 1'b1, 1'b0);
        apply_stimulus(32'h0B04_0B03, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (o_done) found = 1'b1;
        end
        check_output("e_trunc_seen", {31'b0, found}, 1);
        check_output("e_trunc_flag", {31'b0, o_trunc}, 1);
        check_output("e_trunc_len", 32'(o_len), 6);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (o_done) found = 1'b1;
        end
        check_output("e_next_seen", {31'b0, found}, 1);
        check_output("e_next_flag", {31'b0, o_trunc}, 0);
        check_output("e_next_len", 32'(o_len), 4);
        tick(4);

        // Flush with level 3, a pending beat and a pop in the same cycle
        ready = 1'b0;
        apply_stimulus(32'h0C02_0C01, 1'b1, 1'b0);
        apply_stimulus(32'h0C04_0C03, 1'b0, 1'b0);
        tick(10);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        check_output("f_level_before", 32'(o_level), 3);
        apply_stimulus(32'h5555_6666, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        flush = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check_output("f_tready_in_flush", {31'b0, s_axis.tready}, 0);
        check_output("f_level_in_flush", 32'(o_level), 3);
        tick(1);
        flush = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        check_output("f_level_after", 32'(o_level), 0);
        check_output("f_valid_after", {31'b0, o_valid}, 0);
        check_output("f_no_done", {31'b0, o_done}, 0);
        check_output("f_len_held", 32'(o_len), 4);
        tick(6);
        check_output("f_idle_discard", 32'(o_level), 0);
        check_output("f_beat_consumed", 32'(tx_q.size()), 0);

        // Asynchronous reset in the middle of a stream, level 5
        apply_stimulus(32'h0D02_0D01, 1'b1, 1'b0);
        apply_stimulus(32'h0D04_0D03, 1'b0, 1'b0);
        apply_stimulus(32'h0D06_0D05, 1'b0, 1'b0);
        tick(12);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        check_output("g_level_before", 32'(o_level), 5);
        rst = 1'b1;
        tx_q.delete();
        #1;
        check_output("g_tready", {31'b0, s_axis.tready}, 0);
        check_output("g_level", 32'(o_level), 0);
        check_output("g_valid", {31'b0, o_valid}, 0);
        check_output("g_sample", 32'(o_sample), 0);
        check_output("g_flags", {30'b0, o_first, o_last}, 0);
        check_output("g_len", 32'(o_len), 0);
        check_output("g_done", {31'b0, o_done || o_trunc}, 0);
        tick(2);
        rst = 1'b0;
        #1 check_output("g_tready_release", {31'b0, s_axis.tready}, 1);

        // Randomized framing and consumer back-pressure
        tick(1);
        for (int i = 0; i < 60; i++)
            apply_stimulus($urandom, (i == 0) || ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (tx_q.size() == 0 && exp_q.size() == 0 && !o_valid) found = 1'b1;
            else tick(1);
        end
        tick(3);
        check_output("h_drained", {31'b0, found}, 1);
        check_output("h_reports_left", 32'(rep_q.size()), 0);
`ifdef DTW_INGEST_STATS_EN
        check_output("h_discard", o_discard, m_discards);
        check_output("h_frames", o_frames, m_frames);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
